// File: rtl/loader_pkg.sv
// Shared types and sizing for the serial instruction loader.
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned COUNT_WIDTH    = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes little-endian into a word; word_full pulses with the last byte,
// while word already presents the completed value.
module word_packer
    import loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        accept,
    input  logic [7:0]                  byte_in,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_full
);

    localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0]           lane;
    logic [8*BYTES_PER_WORD-1:0] word_q;

    always_comb begin
        word                      = word_q;
        word[{lane, 3'b000} +: 8] = byte_in;
        word_full                 = accept && (lane == LANE_W'(BYTES_PER_WORD - 1));
    end

    // Lane counter wraps after the last byte, so the next word starts at [7:0].
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane   <= '0;
            word_q <= '0;
        end else if (accept) begin
            word_q <= word;
            lane   <= lane + 1'b1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Serial boot loader: reads a 16-bit word count then that many little-endian words,
// writing them to instruction memory while holding the core in reset.
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int unsigned              MAX_WORDS     = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     reload,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     cpu_rst,
    output logic                     done,
    output logic                     err
);

    loader_state_t                 state;
    logic [COUNT_WIDTH-1:0]        count;
    logic [COUNT_WIDTH-1:0]        index;
    logic [COUNT_WIDTH:0]          index_next;
    logic [COUNT_WIDTH-1:0]        len_full;
    logic                          accept;
    logic                          pack_clear;
    logic [8*BYTES_PER_WORD-1:0]   word;
    logic                          word_full;

    assign accept     = byte_valid && byte_ready;
    assign pack_clear = reload && ((state == DONE) || (state == ERR));
    assign len_full   = {byte_in, count[7:0]};
    assign index_next = (COUNT_WIDTH + 1)'(index) + (COUNT_WIDTH + 1)'(1);

    word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .accept    (accept && (state == DATA)),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LEN_LO;
            count      <= '0;
            index      <= '0;
            byte_ready <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                LEN_LO: begin
                    if (accept) begin
                        count[7:0] <= byte_in;
                        state      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        count <= len_full;
                        if (len_full == '0) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            cpu_rst    <= 1'b0;
                            byte_ready <= 1'b0;
                        end else if (32'(len_full) > MAX_WORDS) begin
                            state      <= ERR;
                            err        <= 1'b1;
                            byte_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_full) begin
                        wr_en   <= 1'b1;
                        wr_data <= DATA_WIDTH'(word);
                        wr_addr <= BASE_ADDR + ADDRESS_WIDTH'({index, 2'b00});
                        index   <= index_next[COUNT_WIDTH-1:0];
                        // The last word's write and the move to DONE share one edge.
                        if (index_next == {1'b0, count}) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            cpu_rst    <= 1'b0;
                            byte_ready <= 1'b0;
                        end
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        state      <= LEN_LO;
                        count      <= '0;
                        index      <= '0;
                        byte_ready <= 1'b1;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a byte-counting reference model checked every cycle,
// plus literal expectations for each load scenario.
module tb_instr_loader;

    localparam int unsigned AW   = 32;
    localparam logic [31:0] BASE = 32'h0;
    localparam int unsigned MAXW = 1024;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [7:0]  byte_in    = 8'h00;
    logic        byte_valid = 1'b0;
    logic        reload     = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    instr_loader #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (32),
        .BASE_ADDR     (BASE),
        .MAX_WORDS     (MAXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .reload     (reload),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: status 0 = loading, 1 = done, 2 = rejected.
    int          m_status = 0;
    int          m_nbytes = 0;
    int          m_len    = 0;
    int          m_widx   = 0;
    logic [7:0]  m_buf[$];
    logic        m_wr_en  = 1'b0;
    logic [31:0] m_addr   = BASE;
    logic [31:0] m_data   = 32'h0;

    task automatic model_step();
        if (rst) begin
            m_status = 0; m_nbytes = 0; m_len = 0; m_widx = 0;
            m_buf.delete();
            m_wr_en = 1'b0; m_addr = BASE; m_data = 32'h0;
        end else begin
            m_wr_en = 1'b0;
            if (m_status != 0) begin
                if (reload) begin
                    m_status = 0; m_nbytes = 0; m_len = 0; m_widx = 0;
                    m_buf.delete();
                end
            end else if (byte_valid) begin
                m_nbytes++;
                if (m_nbytes == 1) begin
                    m_len = int'(byte_in);
                end else if (m_nbytes == 2) begin
                    m_len = m_len + 256 * int'(byte_in);
                    if (m_len == 0) m_status = 1;
                    else if (m_len > int'(MAXW)) m_status = 2;
                end else begin
                    m_buf.push_back(byte_in);
                    if (m_buf.size() == 4) begin
                        m_wr_en = 1'b1;
                        m_data  = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                        m_addr  = BASE + 32'(4 * m_widx);
                        m_widx++;
                        m_buf.delete();
                        if (m_widx == m_len) m_status = 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (check_en) begin
            cmp("byte_ready", 32'(byte_ready), 32'(m_status == 0));
            cmp("wr_en", 32'(wr_en), 32'(m_wr_en));
            cmp("wr_addr", wr_addr, m_addr);
            cmp("wr_data", wr_data, m_data);
            cmp("cpu_rst", 32'(cpu_rst), 32'(m_status != 1));
            cmp("done", 32'(done), 32'(m_status == 1));
            cmp("err", 32'(err), 32'(m_status == 2));
        end
    end

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    task automatic step(input logic v, input logic [7:0] b, input logic rl, input logic r);
        @(posedge clk);
        #2;
        byte_valid = v;
        byte_in    = b;
        reload     = rl;
        rst        = r;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reload();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic chk_write(input string name, input int i, input logic [31:0] a,
                             input logic [31:0] d);
        if (i < wq_data.size()) begin
            cmp({name, "_addr"}, wq_addr[i], a);
            cmp({name, "_data"}, wq_data[i], d);
        end else begin
            cmp({name, "_missing"}, 32'(wq_data.size()), 32'(i + 1));
        end
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        cmp("rst_ready", 32'(byte_ready), 32'd1);
        cmp("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        cmp("rst_addr", wr_addr, BASE);
        cmp("rst_done", 32'(done), 32'd0);

        // Two-word program.
        clear_log();
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'hA0); send(8'h00);
        send(8'h93); send(8'h05); send(8'h10); send(8'h00);
        idle(3);
        cmp("two_nwrites", 32'(wq_data.size()), 32'd2);
        chk_write("two_w0", 0, 32'h0, 32'h00A00513);
        chk_write("two_w1", 1, 32'h4, 32'h00100593);
        cmp("two_done", 32'(done), 32'd1);
        cmp("two_cpu_rst", 32'(cpu_rst), 32'd0);
        send(8'hFF); send(8'hEE);
        idle(2);
        cmp("done_ignores_bytes", 32'(wq_data.size()), 32'd2);

        // Zero-length load.
        do_reload();
        clear_log();
        send(8'h00); send(8'h00);
        idle(1);
        cmp("zero_done", 32'(done), 32'd1);
        cmp("zero_ready", 32'(byte_ready), 32'd0);
        idle(2);
        cmp("zero_nwrites", 32'(wq_data.size()), 32'd0);

        // Oversized length, then recovery.
        do_reload();
        clear_log();
        send(8'h01); send(8'h04); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(2);
        cmp("big_err", 32'(err), 32'd1);
        cmp("big_cpu_rst", 32'(cpu_rst), 32'd1);
        cmp("big_nwrites", 32'(wq_data.size()), 32'd0);
        do_reload();
        cmp("rec_err_clear", 32'(err), 32'd0);
        send(8'h01); send(8'h00); send(8'h67); send(8'h45); send(8'h23); send(8'h01);
        idle(3);
        cmp("rec_nwrites", 32'(wq_data.size()), 32'd1);
        chk_write("rec_w0", 0, 32'h0, 32'h01234567);
        cmp("rec_done", 32'(done), 32'd1);

        // Gapped byte stream.
        do_reload();
        clear_log();
        send(8'h01); idle(1); send(8'h00); idle(1);
        send(8'h78); idle(1); send(8'h56); idle(1);
        send(8'h34); idle(1); send(8'h12); idle(3);
        cmp("gap_nwrites", 32'(wq_data.size()), 32'd1);
        chk_write("gap_w0", 0, 32'h0, 32'h12345678);

        // Reset mid-word discards the partial bytes.
        do_reload();
        clear_log();
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);
        send(8'h01); send(8'h00); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle(3);
        cmp("rstmid_nwrites", 32'(wq_data.size()), 32'd1);
        chk_write("rstmid_w0", 0, 32'h0, 32'hDEADBEEF);

        // Reload and byte_valid together in DONE.
        clear_log();
        step(1'b1, 8'h05, 1'b1, 1'b0);
        idle(1);
        cmp("rl_cpu_rst", 32'(cpu_rst), 32'd1);
        cmp("rl_done", 32'(done), 32'd0);
        cmp("rl_ready", 32'(byte_ready), 32'd1);
        send(8'h00); send(8'h00);
        idle(1);
        cmp("rl_byte_dropped", 32'(done), 32'd1);
        idle(2);
        cmp("rl_nwrites", 32'(wq_data.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
